spi_slave_if: RTL and testbench

- SPI slave front-end that feeds the single-port memory's command interface.
- Deserialises MOSI into 10-bit command words (cmd[9:8] + payload[7:0]) and presents each one as rx_data with a one-cycle rx_valid pulse.
- For read-data commands, waits for the memory's tx_valid, then serialises the returned 8-bit tx_data onto MISO.
- SPI bit clock is the system clock clk; all SPI pins are sampled and driven on rising clk edges.

---
 rtl/spi_slave_if.sv | 162 ++++++++++++++++
 tb/tb_spi_slave_if.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front-end for the single-port memory command interface.
// Deserialises one 10-bit command word per SS_n low period (MSB first),
// strobes it out on rx_data/rx_valid, and for read-data commands returns
// the memory's tx_data on MISO, MSB first. clk doubles as the SPI bit clock.
module spi_slave_if #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam int CNT_W = $clog2(((WORD_W > DATA_W) ? WORD_W : DATA_W) + 1);
  // Nine payload-side bits follow the command MSB; their counter runs 0..WORD_W-2.
  localparam logic [CNT_W-1:0] LAST_IN_BIT = CNT_W'(WORD_W - 2);
  localparam logic [CNT_W-1:0] TX_BITS     = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  // Progress inside a transaction once the command bit has been decoded.
  typedef enum logic [1:0] {
    PH_SHIFT_IN,   // collecting word bits 8..0
    PH_WAIT_TX,    // read-data word done, waiting for tx_valid
    PH_SHIFT_OUT,  // driving read data on MISO
    PH_DONE        // nothing more to do until SS_n rises
  } phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WORD_W-2:0]  word_q;       // bits 9..1 of the word being assembled
  logic [WORD_W-1:0]  rx_data_q;
  logic               rx_valid_q;
  logic               rd_addr_seen_q;
  logic [DATA_W-1:0]  tx_shift_q;
  logic               miso_q;

  logic in_shift_state;
  logic cmd_capture;
  logic shift_in_en;
  logic word_done;
  logic tx_capture;
  logic tx_shifting;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers update
      // from the same pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // Next-state decode; SS_n high always returns to IDLE.
  always_comb begin
    // NOTE: defaulting every comb output first keeps unlisted paths from
    // holding their old value, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                 state_d = IDLE;
        else if (!MOSI)           state_d = WRITE;
        else if (!rd_addr_seen_q) state_d = READ_ADD;
        else                      state_d = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes derived from state, phase and the sampled pins.
  always_comb begin
    in_shift_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    cmd_capture    = (state_q == CHK_CMD) && !SS_n;
    shift_in_en    = in_shift_state && (phase_q == PH_SHIFT_IN) && !SS_n;
    word_done      = shift_in_en && (bit_cnt_q == LAST_IN_BIT);
    // The rx_valid cycle itself is skipped so tx_valid is first looked at
    // one cycle after the strobe; a level still high from a prior read is
    // accepted there.
    tx_capture     = (state_q == READ_DATA) && (phase_q == PH_WAIT_TX) &&
                     tx_valid && !rx_valid_q && !SS_n;
    tx_shifting    = (state_q == READ_DATA) && (phase_q == PH_SHIFT_OUT) && !SS_n;
  end

  // Datapath: word assembly, rx strobe, rd_addr_seen tracking, MISO shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= PH_SHIFT_IN;
      bit_cnt_q      <= '0;
      word_q         <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      if (SS_n) begin
        // Idle or abort: the partial word is simply never published.
        bit_cnt_q <= '0;
        phase_q   <= PH_SHIFT_IN;
      end else begin
        if (cmd_capture) begin
          word_q    <= {word_q[WORD_W-3:0], MOSI};
          bit_cnt_q <= '0;
          phase_q   <= PH_SHIFT_IN;
        end
        if (shift_in_en) begin
          if (word_done) begin
            rx_data_q  <= {word_q, MOSI};
            rx_valid_q <= 1'b1;
            bit_cnt_q  <= '0;
            phase_q    <= (state_q == READ_DATA) ? PH_WAIT_TX : PH_DONE;
            if (state_q == READ_ADD)  rd_addr_seen_q <= 1'b1;
            if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
          end else begin
            word_q    <= {word_q[WORD_W-3:0], MOSI};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        if (tx_capture) begin
          // MSB goes out immediately; the rest waits in the shifter.
          miso_q     <= tx_data[DATA_W-1];
          tx_shift_q <= {tx_data[DATA_W-2:0], 1'b0};
          bit_cnt_q  <= CNT_W'(1);
          phase_q    <= PH_SHIFT_OUT;
        end
        if (tx_shifting) begin
          if (bit_cnt_q == TX_BITS) begin
            phase_q <= PH_DONE;
          end else begin
            miso_q     <= tx_shift_q[DATA_W-1];
            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed scenarios plus randomized
// transactions, each scored cycle by cycle against a transaction-level model.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: last published word and whether a read address is pending.
  logic [9:0] m_rx_data;
  bit         m_seen;

  spi_slave_if #(.WORD_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SS_n-low transaction. SS_n falls in cycle 0, word bit 9..0 sit on
  // MOSI in cycles 1..10. nbits < 10 raises SS_n in cycle nbits+1 (abort).
  // tx_valid is high (with td) from cycle t_on onward.
  task automatic txn(input logic [9:0] word, input int nbits, input int t_on,
                     input logic [7:0] td);
    bit   completes;
    bit   is_rd;
    int   cap;
    int   k;
    logic exp_miso;
    completes = (nbits >= 10);
    is_rd     = completes && word[9] && m_seen;
    // Earliest tx_valid sample is the cycle after the rx_valid cycle (11).
    cap       = (t_on > 12) ? t_on : 12;
    for (int c = 0; c <= 32; c++) begin
      SS_n     = (!completes && c > nbits) ? 1'b1 : 1'b0;
      MOSI     = (c >= 1 && c <= 10) ? word[10-c] : 1'($urandom);
      tx_valid = (c >= t_on);
      tx_data  = (c >= t_on) ? td : 8'($urandom);
      step();
      k = c + 1;
      exp_miso = (is_rd && k >= cap + 1 && k <= cap + 8) ? td[7-(k-cap-1)] : 1'b0;
      check("rx_valid", k, rx_valid, (completes && k == 11));
      check("rx_data", k, rx_data, (completes && k >= 11) ? word : m_rx_data);
      check("MISO", k, MISO, exp_miso);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    step();
    check("MISO_idle", 0, MISO, 1'b0);
    step();
    if (completes) begin
      m_rx_data = word;
      if (word[9]) m_seen = !m_seen;
    end
    check("rd_addr_seen", 0, dut.rd_addr_seen_q, m_seen);
  endtask

  logic [9:0] w;
  logic [7:0] d;
  int         nb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    m_rx_data = 10'h000;
    m_seen    = 1'b0;
    #1;
    check("reset_MISO", 0, MISO, 1'b0);
    check("reset_rx_data", 0, rx_data, 10'h000);
    check("reset_rx_valid", 0, rx_valid, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Write address, then write data.
    txn(10'h0A5, 10, 100, 8'h00);
    txn(10'h13C, 10, 100, 8'h00);

    // Read address then read data returning 0xC3 after a short delay.
    txn(10'h207, 10, 100, 8'h00);
    w = {2'b11, 8'($urandom)};
    txn(w, 10, 14, 8'hC3);

    // Abort after 5 bits of a write, then a full write.
    txn(10'h0FF, 5, 100, 8'h00);
    txn(10'h05A, 10, 100, 8'h00);
    // Abort on the very edge that would complete the word.
    txn(10'h1E1, 9, 100, 8'h00);

    // Stale tx_valid: left high from one read into the next read-data word.
    txn(10'h211, 10, 100, 8'h00);
    txn({2'b11, 8'($urandom)}, 10, 13, 8'h96);
    txn(10'h2AA, 10, 0, 8'h4E);
    txn({2'b11, 8'($urandom)}, 10, 0, 8'h4E);

    // Randomized command mix with occasional aborts.
    for (int i = 0; i < 16; i++) begin
      w  = 10'($urandom);
      d  = 8'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
      txn(w, nb, int'($urandom_range(6, 20)), d);
    end

    // Reset in the middle of the MISO shift of a read-data transaction.
    if (!m_seen) txn(10'h233, 10, 100, 8'h00);
    d = 8'($urandom);
    w = {2'b11, 8'($urandom)};
    for (int c = 0; c <= 14; c++) begin
      SS_n     = 1'b0;
      MOSI     = (c >= 1 && c <= 10) ? w[10-c] : 1'b0;
      tx_valid = 1'b1;
      tx_data  = d;
      step();
    end
    // Capture at cycle 12, so cycle 15 carries tx_data bit 5.
    check("pre_reset_MISO", 15, MISO, d[5]);
    rst_n = 1'b0;
    #1;
    m_seen    = 1'b0;
    m_rx_data = 10'h000;
    check("midreset_MISO", 15, MISO, 1'b0);
    check("midreset_rx_valid", 15, rx_valid, 1'b0);
    check("midreset_rx_data", 15, rx_data, 10'h000);
    check("midreset_seen", 15, dut.rd_addr_seen_q, m_seen);
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // A read command after reset must be treated as a read address.
    txn({2'b10, 8'($urandom)}, 10, 6, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
